// File: rtl/fa4_prog_mem.sv
// fa4_prog_mem: nibble-wide program memory for the FA4 CPU.
// The CPU reads through a one-cycle pipelined port while run_mode=1. While run_mode=0,
// a front-panel loader takes debounced KEY presses and writes the SW nibble at an
// auto-incrementing load pointer. The two modes never overlap, so the single array
// never sees a read and a write in the same cycle.
module fa4_prog_mem #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter int DEB_TICKS = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_mode,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              key_n,
    input  logic [DATA_W-1:0] sw_in,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_wr,
    output logic              load_full
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    // Loader states: wait for press, debounce it, write once, wait for release, debounce it.
    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        WRITE,
        WAIT_REL,
        DEB_REL
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             sync_1;
    logic             sync_2;
    logic             key;
    logic             run_q;
    logic             run_fall;
    logic             do_write;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Two-flop synchroniser for the asynchronous pushbutton; both flops idle at released (1).
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so sync_2 takes sync_1's value from before this edge.
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    // Pressed-high view of the synchronised key.
    assign key = ~sync_2;

    // Remember last cycle's mode so a run->load transition can open a new load session.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_mode;
        end
    end

    assign run_fall = run_q & ~run_mode;

    // Loader next-state logic: debounce press and release, one write per accepted press.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        do_write   = 1'b0;
        if (run_mode || run_fall) begin
            // Loader is parked whenever the CPU owns the memory, and restarts clean on return.
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key) begin
                        state_next = DEB_PRESS;
                        cnt_next   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!key) begin
                        state_next = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_next = WRITE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    // A full session swallows further presses without writing.
                    do_write   = ~load_full;
                    state_next = WAIT_REL;
                end
                WAIT_REL: begin
                    if (!key) begin
                        state_next = DEB_REL;
                        cnt_next   = '0;
                    end
                end
                DEB_REL: begin
                    if (key) begin
                        state_next = WAIT_REL;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Loader state, debounce counter, load pointer, write pulse and full flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            load_addr <= '0;
            load_full <= 1'b0;
            load_wr   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            load_wr <= do_write;
            if (run_fall) begin
                load_addr <= '0;
                load_full <= 1'b0;
            end else if (do_write) begin
                load_addr <= load_addr + ADDR_W'(1);
                if (&load_addr) begin
                    load_full <= 1'b1;
                end
            end
        end
    end

    // Loader write port; a reset in the WRITE cycle suppresses the write.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; program contents survive reset and it maps onto block RAM.
        if (do_write && !reset) begin
            mem[load_addr] <= sw_in;
        end
    end

    // CPU read port: one-cycle latency, a new request may be issued every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req & run_mode;
            if (rd_req && run_mode) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Structural invariants of the loader and read port.
    a_wr_single : assert property (@(posedge clock) disable iff (reset) load_wr |=> !load_wr);
    a_full_wrap : assert property (@(posedge clock) disable iff (reset) load_full |-> (load_addr == '0));
    a_rd_mode   : assert property (@(posedge clock) disable iff (reset) rd_valid |-> $past(run_mode));

endmodule

// File: tb/tb_fa4_prog_mem.sv
// tb_fa4_prog_mem: directed front-panel and CPU-read scenarios followed by random
// key/mode/read traffic, all compared every cycle against a run-length behavioural model.
module tb_fa4_prog_mem;

    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 4;
    localparam int DEB_TICKS = 500;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              run_mode;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              key_n;
    logic [DATA_W-1:0] sw_in;
    logic [ADDR_W-1:0] load_addr;
    logic              load_wr;
    logic              load_full;

    int vectors     = 0;
    int miscompares = 0;
    int wr_pulses   = 0;

    always #5 clock = ~clock;

    fa4_prog_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEB_TICKS(DEB_TICKS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .run_mode (run_mode),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .key_n    (key_n),
        .sw_in    (sw_in),
        .load_addr(load_addr),
        .load_wr  (load_wr),
        .load_full(load_full)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The key is seen two edges late. A press is accepted once the pressed level has
    // been seen on DEB_TICKS+1 consecutive cycles while armed; the following cycle is
    // the write. Re-arming needs DEB_TICKS+1 consecutive released cycles.
    typedef enum {ARMED, WRITING, RELEASING} phase_t;

    phase_t            phase = ARMED;
    int                run_len = 0;
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    logic              dly     [2];
    bit                m_prev_run = 1'b0;
    bit                m_valid    = 1'b0;
    logic [ADDR_W-1:0] e_addr;
    logic              e_full;
    logic              e_wr;
    logic              e_rd_valid;
    logic [DATA_W-1:0] e_rd_data;
    bit                e_rd_known;
    logic              m_key;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end

    always @(posedge clock) begin
        if (reset) begin
            phase      = ARMED;
            run_len    = 0;
            dly[0]     = 1'b1;
            dly[1]     = 1'b1;
            m_prev_run = 1'b0;
            e_addr     = '0;
            e_full     = 1'b0;
            e_wr       = 1'b0;
            e_rd_valid = 1'b0;
            e_rd_data  = '0;
            e_rd_known = 1'b1;
            m_valid    = 1'b1;
        end else begin
            m_key      = ~dly[1];
            e_rd_valid = rd_req && run_mode;
            if (rd_req && run_mode) begin
                e_rd_data  = m_mem[int'(rd_addr)];
                e_rd_known = m_known[int'(rd_addr)];
            end
            e_wr = 1'b0;
            if (run_mode || (m_prev_run && !run_mode)) begin
                if (!run_mode) begin
                    e_addr = '0;
                    e_full = 1'b0;
                end
                phase   = ARMED;
                run_len = 0;
            end else begin
                case (phase)
                    ARMED: begin
                        run_len = m_key ? run_len + 1 : 0;
                        if (run_len == DEB_TICKS + 1) phase = WRITING;
                    end
                    WRITING: begin
                        if (!e_full) begin
                            m_mem[int'(e_addr)]   = sw_in;
                            m_known[int'(e_addr)] = 1'b1;
                            e_wr = 1'b1;
                            if (int'(e_addr) == DEPTH - 1) e_full = 1'b1;
                            e_addr = ADDR_W'((int'(e_addr) + 1) % DEPTH);
                        end
                        phase   = RELEASING;
                        run_len = 0;
                    end
                    default: begin
                        run_len = m_key ? 0 : run_len + 1;
                        if (run_len == DEB_TICKS + 1) begin
                            phase   = ARMED;
                            run_len = 0;
                        end
                    end
                endcase
            end
            m_prev_run = run_mode;
            dly[1]     = dly[0];
            dly[0]     = key_n;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("rd_valid", rd_valid, e_rd_valid);
            if (e_rd_known) check("rd_data", rd_data, e_rd_data);
            check("load_addr", load_addr, e_addr);
            check("load_full", load_full, e_full);
            check("load_wr", load_wr, e_wr);
        end
        if (load_wr === 1'b1) wr_pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [DATA_W-1:0] v);
        sw_in = v;
        key_n = 1'b0;
        repeat (600) @(negedge clock);
        key_n = 1'b1;
        repeat (600) @(negedge clock);
    endtask

    int hold;

    initial begin
        reset    = 1'b1;
        run_mode = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        key_n    = 1'b1;
        sw_in    = 4'hA;
        repeat (3) @(negedge clock);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_load_addr", load_addr, 0);
        check("rst_load_full", load_full, 0);
        check("rst_load_wr", load_wr, 0);
        reset = 1'b0;

        // One long press: exactly one write of A at address 0.
        press(4'hA);
        check("press1_pulses", wr_pulses, 1);
        check("press1_addr", load_addr, 1);

        // Short glitch is rejected.
        key_n = 1'b0;
        repeat (100) @(negedge clock);
        key_n = 1'b1;
        repeat (200) @(negedge clock);
        check("glitch_pulses", wr_pulses, 1);
        check("glitch_addr", load_addr, 1);

        // Finish A,5,3 and read them back-to-back.
        press(4'h5);
        press(4'h3);
        check("load3_addr", load_addr, 3);
        run_mode = 1'b1;
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 2'd0;
        @(negedge clock);
        check("rd0_valid", rd_valid, 1);
        check("rd0_data", rd_data, 4'hA);
        rd_addr = 2'd1;
        @(negedge clock);
        check("rd1_valid", rd_valid, 1);
        check("rd1_data", rd_data, 4'h5);
        rd_addr = 2'd2;
        @(negedge clock);
        check("rd2_valid", rd_valid, 1);
        check("rd2_data", rd_data, 4'h3);
        rd_req = 1'b0;
        @(negedge clock);
        check("rd_idle_valid", rd_valid, 0);
        check("run_addr_hold", load_addr, 3);

        // New session, fill all DEPTH locations, then one extra press.
        run_mode = 1'b0;
        @(negedge clock);
        check("session_addr", load_addr, 0);
        for (int i = 1; i <= DEPTH; i++) press(DATA_W'(i));
        check("wrap_full", load_full, 1);
        check("wrap_addr", load_addr, 0);
        check("wrap_pulses", wr_pulses, 3 + DEPTH);
        press(4'hF);
        check("full_pulses", wr_pulses, 3 + DEPTH);
        check("full_flag", load_full, 1);
        run_mode = 1'b1;
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 2'd0;
        @(negedge clock);
        check("full_mem0", rd_data, 4'h1);
        rd_addr = 2'd3;
        @(negedge clock);
        check("full_mem3", rd_data, 4'h4);
        rd_req = 1'b0;

        // Switch to run mode part-way through press debounce: no write.
        run_mode = 1'b0;
        sw_in    = 4'h9;
        @(negedge clock);
        key_n = 1'b0;
        repeat (303) @(negedge clock);
        run_mode = 1'b1;
        repeat (300) @(negedge clock);
        key_n = 1'b1;
        repeat (10) @(negedge clock);
        check("abort_pulses", wr_pulses, 3 + DEPTH);
        check("abort_addr", load_addr, 0);

        // Read requests in load mode are ignored and rd_data holds.
        run_mode = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("ld_rd_valid", rd_valid, 0);
            check("ld_rd_hold", rd_data, 4'h4);
        end
        rd_req = 1'b0;

        // Reset lands exactly on the WRITE cycle: nothing written, outputs back to reset.
        sw_in = 4'hE;
        key_n = 1'b0;
        repeat (503) @(negedge clock);
        reset = 1'b1;
        key_n = 1'b1;
        @(negedge clock);
        check("rstw_pulses", wr_pulses, 3 + DEPTH);
        check("rstw_rd_data", rd_data, 0);
        check("rstw_rd_valid", rd_valid, 0);
        check("rstw_addr", load_addr, 0);
        check("rstw_full", load_full, 0);
        check("rstw_wr", load_wr, 0);
        reset    = 1'b0;
        run_mode = 1'b1;
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 2'd0;
        @(negedge clock);
        check("rstw_mem0", rd_data, 4'h1);
        rd_req   = 1'b0;
        run_mode = 1'b0;

        // Random traffic against the model.
        hold = 0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clock);
            if (hold == 0) begin
                key_n = ~key_n;
                hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                                    : int'($urandom_range(480, 720));
            end else begin
                hold--;
            end
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = ADDR_W'($urandom);
            sw_in   = DATA_W'($urandom);
            if ($urandom_range(0, 3999) == 0) run_mode = ~run_mode;
            reset = ($urandom_range(0, 9999) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
